fmrv32im_axim_arb: RTL and testbench
====================================

FMRV32IM_AXIM_ARB -- requirements
Module: fmrv32im_axim_arb

Interface
REQ-001 SHALL provide parameter MEMA_W, default 10, local buffer address width of the MEM_ADDR ports.
REQ-002 SHALL provide port `RST_N`: in, 1 bit, asynchronous active-low reset.
REQ-003 SHALL provide port `CLK`: in, 1 bit, the single clock; all state is on its rising edge.
REQ-004 SHALL provide `S_WR_REQ_START` / `S_RD_REQ_START`: in, 2 bits, start pulse per requester (bit i = requester i; 0 = cache, 1 = auxiliary master).
REQ-005 SHALL provide `S_WR_REQ_ADDR` / `S_RD_REQ_ADDR`: in, 2x32 bits, burst byte address per requester.
REQ-006 SHALL provide `S_WR_REQ_LEN` / `S_RD_REQ_LEN`: in, 2x16 bits, burst length per requester.
REQ-007 SHALL provide `S_WR_REQ_READY` / `S_RD_REQ_READY`: out, 2 bits, requester may issue START.
REQ-008 SHALL provide `S_WR_REQ_MEM_WDATA`: in, 2x32 bits, write data per requester.
REQ-009 SHALL provide `S_WR_REQ_MEM_ADDR` / `S_RD_REQ_MEM_ADDR`: out, MEMA_W bits, broadcast buffer address.
REQ-010 SHALL provide `S_RD_REQ_MEM_WE`: out, 2 bits, read-data write strobe per requester.
REQ-011 SHALL provide `S_RD_REQ_MEM_RDATA`: out, 32 bits, broadcast read data.
REQ-012 SHALL provide `M_WR_REQ_START` / `M_RD_REQ_START`: out, 1 bit, to the AXI4 master engine.
REQ-013 SHALL provide `M_WR_REQ_ADDR` / `M_RD_REQ_ADDR`: out, 32 bits.
REQ-014 SHALL provide `M_WR_REQ_LEN` / `M_RD_REQ_LEN`: out, 16 bits.
REQ-015 SHALL provide `M_WR_REQ_READY` / `M_RD_REQ_READY`: in, 1 bit.
REQ-016 SHALL provide `M_WR_REQ_MEM_ADDR` / `M_RD_REQ_MEM_ADDR`: in, MEMA_W bits.
REQ-017 SHALL provide `M_WR_REQ_MEM_WDATA`: out, 32 bits.
REQ-018 SHALL provide `M_RD_REQ_MEM_WE`: in, 1 bit.
REQ-019 SHALL provide `M_RD_REQ_MEM_RDATA`: in, 32 bits.

Function
REQ-020 The write and read channels SHALL each be arbitrated by an independent, identical engine; the two SHALL never interact.
REQ-021 On `S_*_START[i]` with `S_*_READY[i]`=1, the engine SHALL latch ADDR/LEN into pending slot i and drive `S_*_READY[i]`=0 from the next cycle.
REQ-022 `S_*_READY[i]` SHALL equal NOT pending[i]; a START while pending[i] SHALL be ignored (protocol violation).
REQ-023 The per-channel FSM SHALL have states IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.
REQ-024 IDLE->ISSUE SHALL occur when any pending bit is set and `M_*_READY`=1; grant is selected that cycle.
REQ-025 In ISSUE, `M_*_START` SHALL be 1 for exactly one cycle with the granted slot's ADDR/LEN, then go to WAIT_LOW.
REQ-026 WAIT_LOW->WAIT_HIGH SHALL occur on `M_*_READY`=0.
REQ-027 WAIT_HIGH->IDLE SHALL occur on `M_*_READY`=1, clearing pending[grant], so `S_*_READY[grant]`=1 the following cycle.
REQ-028 Minimum latency from requester START to `M_*_START` SHALL be 2 cycles.
REQ-029 `M_*_ADDR`/`M_*_LEN` SHALL hold the granted values from ISSUE through WAIT_HIGH.
REQ-030 `M_WR_REQ_MEM_WDATA` SHALL be `S_WR_REQ_MEM_WDATA[grant]`.
REQ-031 `S_RD_REQ_MEM_WE[i]` SHALL be `M_RD_REQ_MEM_WE` AND (grant==i) AND state!=IDLE.
REQ-032 MEM_ADDR and RDATA SHALL pass through combinationally.
REQ-033 If both requesters are pending in IDLE, the grant SHALL go to the priority pointer; the pointer SHALL update on WAIT_HIGH->IDLE.
REQ-034 LEN SHALL pass through unmodified, including 0.

Reset
REQ-035 While `RST_N`=0: state IDLE, pending=0, grant=0, pointer=0, `M_*_START`=0, `M_*_ADDR`/`M_*_LEN`=0, `S_*_READY`=2'b11, `S_RD_REQ_MEM_WE`=0.
REQ-036 Reset mid-burst SHALL abandon the transaction; the AXI master engine is reset by the same `RST_N`.

Configuration
REQ-037 With `FMRV32IM_AXIM_ARB_RR_EN` defined, the pointer SHALL move to the non-granted requester after each completion (round-robin).
REQ-038 Without `FMRV32IM_AXIM_ARB_RR_EN`, the pointer SHALL be fixed at 0, giving requester 0 fixed priority.

Structure
REQ-039 Package `fmrv32im_axim_arb_pkg` SHALL hold the FSM state enum, NREQ=2 and LEN_W=16.
REQ-040 One sub-module `fmrv32im_axim_arb_ch` (single channel engine) SHALL be instantiated twice.
REQ-041 The channel engine's WDATA/MEM_WE muxing SHALL be enabled by a per-instance parameter.

Verification
REQ-042 Bench SHALL cover: single RD start on req0 (ADDR=0x1000, LEN=16) -> `M_RD_REQ_START` pulse 2 cycles later, `S_RD_REQ_READY[0]` returns to 1 one cycle after `M_RD_REQ_READY` rises.
REQ-043 Bench SHALL cover: simultaneous WR starts req0/req1 with RR -> order req0 then req1; without macro, repeated simultaneous starts -> req0 always first.
REQ-044 Bench SHALL cover: concurrent RD on req1 and WR on req0 -> both `M_*_START` pulse in the same cycle.
REQ-045 Bench SHALL cover: `M_RD_REQ_MEM_WE` pulses with RDATA=0xDEADBEEF while req1 is granted -> only `S_RD_REQ_MEM_WE[1]`=1.
REQ-046 Bench SHALL cover: second START on req0 while pending -> ignored, exactly one `M_*_START`.
REQ-047 Bench SHALL cover: `RST_N` asserted in WAIT_HIGH -> all outputs take reset values, `S_*_READY`=2'b11.

Source files
------------

// File: rtl/fmrv32im_axim_arb_pkg.sv
// rtl/fmrv32im_axim_arb_pkg.sv - shared constants and FSM state type for the AXI master arbiter
package fmrv32im_axim_arb_pkg;

  localparam int NREQ  = 2;
  localparam int LEN_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_LOW  = 2'd2,
    ST_WAIT_HIGH = 2'd3
  } arb_state_e;

endpackage

// File: rtl/fmrv32im_axim_arb_ch.sv
// rtl/fmrv32im_axim_arb_ch.sv - one channel engine: two pending slots arbitrated onto a single master request
// FMRV32IM_AXIM_ARB_RR_EN selects round-robin pointer update; otherwise requester 0 has fixed priority.
module fmrv32im_axim_arb_ch
  import fmrv32im_axim_arb_pkg::*;
#(
  parameter bit WR_CH = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_start,
  input  logic [NREQ-1:0][31:0]      req_addr,
  input  logic [NREQ-1:0][LEN_W-1:0] req_len,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][31:0]      req_wdata,
  output logic [NREQ-1:0]            req_mem_we,
  output logic                       m_start,
  output logic [31:0]                m_addr,
  output logic [LEN_W-1:0]           m_len,
  input  logic                       m_ready,
  output logic [31:0]                m_wdata,
  input  logic                       m_mem_we
);

  arb_state_e                 state;
  logic [NREQ-1:0]            pending;
  logic                       grant;
  logic                       ptr;
  logic                       sel;
  logic [NREQ-1:0][31:0]      slot_addr;
  logic [NREQ-1:0][LEN_W-1:0] slot_len;

  // The pointer only matters when both slots contend.
  assign sel = (&pending) ? ptr : pending[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pending   <= '0;
      grant     <= 1'b0;
      ptr       <= 1'b0;
      m_start   <= 1'b0;
      m_addr    <= '0;
      m_len     <= '0;
      slot_addr <= '0;
      slot_len  <= '0;
    end else begin
      m_start <= 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (req_start[i] && !pending[i]) begin
          pending[i]   <= 1'b1;
          slot_addr[i] <= req_addr[i];
          slot_len[i]  <= req_len[i];
        end
      end
      case (state)
        ST_IDLE: begin
          if ((|pending) && m_ready) begin
            grant   <= sel;
            m_start <= 1'b1;
            m_addr  <= slot_addr[sel];
            m_len   <= slot_len[sel];
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT_LOW;
        ST_WAIT_LOW: begin
          if (!m_ready) state <= ST_WAIT_HIGH;
        end
        ST_WAIT_HIGH: begin
          if (m_ready) begin
            pending[grant] <= 1'b0;
`ifdef FMRV32IM_AXIM_ARB_RR_EN
            ptr <= ~grant;
`else
            ptr <= 1'b0;
`endif
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = ~pending;
  // The disabled data path of each instance drives zero so the top can merge by OR.
  assign m_wdata    = WR_CH ? req_wdata[grant] : 32'd0;
  assign req_mem_we = {NREQ{!WR_CH && m_mem_we && (state != ST_IDLE)}} & {grant, ~grant};

endmodule

// File: rtl/fmrv32im_axim_arb.sv
// rtl/fmrv32im_axim_arb.sv - arbitrates cache and auxiliary master onto one AXI4 master engine
// FMRV32IM_AXIM_ARB_RR_EN enables round-robin arbitration in both channel engines.
module fmrv32im_axim_arb
  import fmrv32im_axim_arb_pkg::*;
#(
  parameter int MEMA_W = 10
) (
  input  logic                       RST_N,
  input  logic                       CLK,

  input  logic [NREQ-1:0]            S_WR_REQ_START,
  input  logic [NREQ-1:0][31:0]      S_WR_REQ_ADDR,
  input  logic [NREQ-1:0][LEN_W-1:0] S_WR_REQ_LEN,
  output logic [NREQ-1:0]            S_WR_REQ_READY,
  output logic [MEMA_W-1:0]          S_WR_REQ_MEM_ADDR,
  input  logic [NREQ-1:0][31:0]      S_WR_REQ_MEM_WDATA,

  input  logic [NREQ-1:0]            S_RD_REQ_START,
  input  logic [NREQ-1:0][31:0]      S_RD_REQ_ADDR,
  input  logic [NREQ-1:0][LEN_W-1:0] S_RD_REQ_LEN,
  output logic [NREQ-1:0]            S_RD_REQ_READY,
  output logic [MEMA_W-1:0]          S_RD_REQ_MEM_ADDR,
  output logic [NREQ-1:0]            S_RD_REQ_MEM_WE,
  output logic [31:0]                S_RD_REQ_MEM_RDATA,

  output logic                       M_WR_REQ_START,
  output logic [31:0]                M_WR_REQ_ADDR,
  output logic [LEN_W-1:0]           M_WR_REQ_LEN,
  input  logic                       M_WR_REQ_READY,
  input  logic [MEMA_W-1:0]          M_WR_REQ_MEM_ADDR,
  output logic [31:0]                M_WR_REQ_MEM_WDATA,

  output logic                       M_RD_REQ_START,
  output logic [31:0]                M_RD_REQ_ADDR,
  output logic [LEN_W-1:0]           M_RD_REQ_LEN,
  input  logic                       M_RD_REQ_READY,
  input  logic [MEMA_W-1:0]          M_RD_REQ_MEM_ADDR,
  input  logic                       M_RD_REQ_MEM_WE,
  input  logic [31:0]                M_RD_REQ_MEM_RDATA
);

  logic [NREQ-1:0] wr_mem_we;
  logic [NREQ-1:0] rd_mem_we;
  logic [31:0]     wr_wdata;
  logic [31:0]     rd_wdata;

  fmrv32im_axim_arb_ch #(.WR_CH(1'b1)) u_wr (
    .clk        (CLK),
    .rst_n      (RST_N),
    .req_start  (S_WR_REQ_START),
    .req_addr   (S_WR_REQ_ADDR),
    .req_len    (S_WR_REQ_LEN),
    .req_ready  (S_WR_REQ_READY),
    .req_wdata  (S_WR_REQ_MEM_WDATA),
    .req_mem_we (wr_mem_we),
    .m_start    (M_WR_REQ_START),
    .m_addr     (M_WR_REQ_ADDR),
    .m_len      (M_WR_REQ_LEN),
    .m_ready    (M_WR_REQ_READY),
    .m_wdata    (wr_wdata),
    .m_mem_we   (1'b0)
  );

  fmrv32im_axim_arb_ch #(.WR_CH(1'b0)) u_rd (
    .clk        (CLK),
    .rst_n      (RST_N),
    .req_start  (S_RD_REQ_START),
    .req_addr   (S_RD_REQ_ADDR),
    .req_len    (S_RD_REQ_LEN),
    .req_ready  (S_RD_REQ_READY),
    .req_wdata  ('0),
    .req_mem_we (rd_mem_we),
    .m_start    (M_RD_REQ_START),
    .m_addr     (M_RD_REQ_ADDR),
    .m_len      (M_RD_REQ_LEN),
    .m_ready    (M_RD_REQ_READY),
    .m_wdata    (rd_wdata),
    .m_mem_we   (M_RD_REQ_MEM_WE)
  );

  assign S_RD_REQ_MEM_WE    = rd_mem_we | wr_mem_we;
  assign M_WR_REQ_MEM_WDATA = wr_wdata | rd_wdata;

  assign S_WR_REQ_MEM_ADDR  = M_WR_REQ_MEM_ADDR;
  assign S_RD_REQ_MEM_ADDR  = M_RD_REQ_MEM_ADDR;
  assign S_RD_REQ_MEM_RDATA = M_RD_REQ_MEM_RDATA;

endmodule

// File: tb/tb_fmrv32im_axim_arb.sv
// tb/tb_fmrv32im_axim_arb.sv - scoreboard bench for the AXI master arbiter
// Honours FMRV32IM_AXIM_ARB_RR_EN for the expected grant order.
module tb_fmrv32im_axim_arb;

  logic             RST_N;
  logic             CLK;
  logic [1:0]       S_WR_REQ_START;
  logic [1:0][31:0] S_WR_REQ_ADDR;
  logic [1:0][15:0] S_WR_REQ_LEN;
  logic [1:0]       S_WR_REQ_READY;
  logic [9:0]       S_WR_REQ_MEM_ADDR;
  logic [1:0][31:0] S_WR_REQ_MEM_WDATA;
  logic [1:0]       S_RD_REQ_START;
  logic [1:0][31:0] S_RD_REQ_ADDR;
  logic [1:0][15:0] S_RD_REQ_LEN;
  logic [1:0]       S_RD_REQ_READY;
  logic [9:0]       S_RD_REQ_MEM_ADDR;
  logic [1:0]       S_RD_REQ_MEM_WE;
  logic [31:0]      S_RD_REQ_MEM_RDATA;
  logic             M_WR_REQ_START;
  logic [31:0]      M_WR_REQ_ADDR;
  logic [15:0]      M_WR_REQ_LEN;
  logic             M_WR_REQ_READY;
  logic [9:0]       M_WR_REQ_MEM_ADDR;
  logic [31:0]      M_WR_REQ_MEM_WDATA;
  logic             M_RD_REQ_START;
  logic [31:0]      M_RD_REQ_ADDR;
  logic [15:0]      M_RD_REQ_LEN;
  logic             M_RD_REQ_READY;
  logic [9:0]       M_RD_REQ_MEM_ADDR;
  logic             M_RD_REQ_MEM_WE;
  logic [31:0]      M_RD_REQ_MEM_RDATA;

  fmrv32im_axim_arb #(.MEMA_W(10)) dut (
    .RST_N(RST_N), .CLK(CLK),
    .S_WR_REQ_START(S_WR_REQ_START), .S_WR_REQ_ADDR(S_WR_REQ_ADDR), .S_WR_REQ_LEN(S_WR_REQ_LEN),
    .S_WR_REQ_READY(S_WR_REQ_READY), .S_WR_REQ_MEM_ADDR(S_WR_REQ_MEM_ADDR),
    .S_WR_REQ_MEM_WDATA(S_WR_REQ_MEM_WDATA),
    .S_RD_REQ_START(S_RD_REQ_START), .S_RD_REQ_ADDR(S_RD_REQ_ADDR), .S_RD_REQ_LEN(S_RD_REQ_LEN),
    .S_RD_REQ_READY(S_RD_REQ_READY), .S_RD_REQ_MEM_ADDR(S_RD_REQ_MEM_ADDR),
    .S_RD_REQ_MEM_WE(S_RD_REQ_MEM_WE), .S_RD_REQ_MEM_RDATA(S_RD_REQ_MEM_RDATA),
    .M_WR_REQ_START(M_WR_REQ_START), .M_WR_REQ_ADDR(M_WR_REQ_ADDR), .M_WR_REQ_LEN(M_WR_REQ_LEN),
    .M_WR_REQ_READY(M_WR_REQ_READY), .M_WR_REQ_MEM_ADDR(M_WR_REQ_MEM_ADDR),
    .M_WR_REQ_MEM_WDATA(M_WR_REQ_MEM_WDATA),
    .M_RD_REQ_START(M_RD_REQ_START), .M_RD_REQ_ADDR(M_RD_REQ_ADDR), .M_RD_REQ_LEN(M_RD_REQ_LEN),
    .M_RD_REQ_READY(M_RD_REQ_READY), .M_RD_REQ_MEM_ADDR(M_RD_REQ_MEM_ADDR),
    .M_RD_REQ_MEM_WE(M_RD_REQ_MEM_WE), .M_RD_REQ_MEM_RDATA(M_RD_REQ_MEM_RDATA)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] len;
  } exp_t;

  exp_t wr_q[$];
  exp_t rd_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   wr_starts = 0;
  int   rd_starts = 0;
  logic wr_stall = 1'b0;
  logic rd_stall = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitors: each master start must match the oldest expected request.
  always @(negedge CLK) begin
    if (M_WR_REQ_START) begin
      wr_starts++;
      if (wr_q.size() == 0) chk("wr_unexpected_start", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = wr_q.pop_front();
        chk("wr_start_addr", {32'd0, M_WR_REQ_ADDR}, {32'd0, e.addr});
        chk("wr_start_len", {48'd0, M_WR_REQ_LEN}, {48'd0, e.len});
      end
    end
    if (M_RD_REQ_START) begin
      rd_starts++;
      if (rd_q.size() == 0) chk("rd_unexpected_start", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = rd_q.pop_front();
        chk("rd_start_addr", {32'd0, M_RD_REQ_ADDR}, {32'd0, e.addr});
        chk("rd_start_len", {48'd0, M_RD_REQ_LEN}, {48'd0, e.len});
      end
    end
  end

  // Master engine models: drop READY on START, raise it after a few cycles unless stalled.
  initial begin
    M_WR_REQ_READY = 1'b1;
    forever begin
      @(negedge CLK);
      if (M_WR_REQ_START) begin
        M_WR_REQ_READY = 1'b0;
        repeat (3) @(negedge CLK);
        while (wr_stall) @(negedge CLK);
        M_WR_REQ_READY = 1'b1;
      end
    end
  end

  initial begin
    M_RD_REQ_READY = 1'b1;
    forever begin
      @(negedge CLK);
      if (M_RD_REQ_START) begin
        M_RD_REQ_READY = 1'b0;
        repeat (3) @(negedge CLK);
        while (rd_stall) @(negedge CLK);
        M_RD_REQ_READY = 1'b1;
      end
    end
  end

  task automatic wr_go(input int i, input logic [31:0] a, input logic [15:0] l, input bit expect_it);
    S_WR_REQ_ADDR[i]  = a;
    S_WR_REQ_LEN[i]   = l;
    S_WR_REQ_START[i] = 1'b1;
    if (expect_it) wr_q.push_back('{addr: a, len: l});
  endtask

  task automatic rd_go(input int i, input logic [31:0] a, input logic [15:0] l, input bit expect_it);
    S_RD_REQ_ADDR[i]  = a;
    S_RD_REQ_LEN[i]   = l;
    S_RD_REQ_START[i] = 1'b1;
    if (expect_it) rd_q.push_back('{addr: a, len: l});
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      #1;
      if (S_WR_REQ_READY == 2'b11 && S_RD_REQ_READY == 2'b11 && M_WR_REQ_READY && M_RD_REQ_READY) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk(name, 64'd0, 64'd1);
  endtask

  task automatic wait_start(input bit is_rd, input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (is_rd ? M_RD_REQ_START : M_WR_REQ_START) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk(name, 64'd0, 64'd1);
  endtask

  initial begin
    int base;
    bit ok;
    RST_N = 1'b0;
    S_WR_REQ_START = '0; S_WR_REQ_ADDR = '0; S_WR_REQ_LEN = '0;
    S_RD_REQ_START = '0; S_RD_REQ_ADDR = '0; S_RD_REQ_LEN = '0;
    S_WR_REQ_MEM_WDATA[0] = 32'hA5A5_0000;
    S_WR_REQ_MEM_WDATA[1] = 32'h5A5A_1111;
    M_WR_REQ_MEM_ADDR = 10'h0AA;
    M_RD_REQ_MEM_ADDR = 10'h155;
    M_RD_REQ_MEM_WE = 1'b1;
    M_RD_REQ_MEM_RDATA = 32'h1234_5678;

    // Reset values, with MEM_WE driven high to prove it is gated.
    repeat (3) @(negedge CLK);
    chk("rst_wr_ready", {62'd0, S_WR_REQ_READY}, 64'd3);
    chk("rst_rd_ready", {62'd0, S_RD_REQ_READY}, 64'd3);
    chk("rst_m_start", {62'd0, M_WR_REQ_START, M_RD_REQ_START}, 64'd0);
    chk("rst_m_addr_len", {M_WR_REQ_ADDR, M_RD_REQ_ADDR}, 64'd0);
    chk("rst_m_len", {32'd0, M_WR_REQ_LEN, M_RD_REQ_LEN}, 64'd0);
    chk("rst_rd_mem_we", {62'd0, S_RD_REQ_MEM_WE}, 64'd0);
    chk("pass_mem_addr", {44'd0, S_WR_REQ_MEM_ADDR, S_RD_REQ_MEM_ADDR}, {44'd0, 10'h0AA, 10'h155});
    chk("pass_rdata", {32'd0, S_RD_REQ_MEM_RDATA}, 64'h1234_5678);
    M_RD_REQ_MEM_WE = 1'b0;
    RST_N = 1'b1;

    // Single read on req0: START latency and READY return.
    @(negedge CLK);
    rd_go(0, 32'h0000_1000, 16'd16, 1'b1);
    @(negedge CLK);
    S_RD_REQ_START = '0;
    chk("rd_lat_cycle1", {63'd0, M_RD_REQ_START}, 64'd0);
    chk("rd_ready_drop", {62'd0, S_RD_REQ_READY}, 64'd2);
    @(negedge CLK);
    chk("rd_lat_cycle2", {63'd0, M_RD_REQ_START}, 64'd1);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      #1;
      if (M_RD_REQ_READY) begin ok = 1'b1; break; end
    end
    if (!ok) chk("rd_ready_rise_timeout", 64'd0, 64'd1);
    chk("rd_ready_still_low", {62'd0, S_RD_REQ_READY}, 64'd2);
    @(negedge CLK);
    chk("rd_ready_return", {62'd0, S_RD_REQ_READY}, 64'd3);
    wait_idle("idle_t1");

    // Simultaneous write starts, twice: req0 first both times.
    for (int r = 0; r < 2; r++) begin
      @(negedge CLK);
      wr_go(0, 32'h0000_2000 + r, 16'd4, 1'b1);
      wr_go(1, 32'h0000_3000 + r, 16'd8, 1'b1);
      @(negedge CLK);
      S_WR_REQ_START = '0;
      wait_idle("idle_t2");
    end

    // After a lone req0 completion, contention exposes the pointer policy.
    @(negedge CLK);
    wr_go(0, 32'h0000_2100, 16'd1, 1'b1);
    @(negedge CLK);
    S_WR_REQ_START = '0;
    wait_idle("idle_t2b");
    @(negedge CLK);
`ifdef FMRV32IM_AXIM_ARB_RR_EN
    wr_go(1, 32'h0000_3200, 16'd3, 1'b1);
    wr_go(0, 32'h0000_2200, 16'd2, 1'b1);
`else
    wr_go(0, 32'h0000_2200, 16'd2, 1'b1);
    wr_go(1, 32'h0000_3200, 16'd3, 1'b1);
`endif
    @(negedge CLK);
    S_WR_REQ_START = '0;
    wait_idle("idle_t2c");

    // Concurrent RD req1 and WR req0; read-data strobe routed to req1 only.
    @(negedge CLK);
    wr_go(0, 32'h0000_4000, 16'd2, 1'b1);
    rd_go(1, 32'h0000_5000, 16'd32, 1'b1);
    @(negedge CLK);
    S_WR_REQ_START = '0;
    S_RD_REQ_START = '0;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (M_WR_REQ_START || M_RD_REQ_START) begin ok = 1'b1; break; end
    end
    if (!ok) chk("concurrent_timeout", 64'd0, 64'd1);
    chk("concurrent_start", {62'd0, M_WR_REQ_START, M_RD_REQ_START}, 64'd3);
    chk("wr_wdata_req0", {32'd0, M_WR_REQ_MEM_WDATA}, 64'hA5A5_0000);
    @(negedge CLK);
    M_RD_REQ_MEM_WE = 1'b1;
    M_RD_REQ_MEM_RDATA = 32'hDEAD_BEEF;
    #1;
    chk("rd_mem_we_req1", {62'd0, S_RD_REQ_MEM_WE}, 64'd2);
    chk("rd_rdata", {32'd0, S_RD_REQ_MEM_RDATA}, 64'hDEAD_BEEF);
    @(negedge CLK);
    M_RD_REQ_MEM_WE = 1'b0;
    #1;
    chk("rd_mem_we_off", {62'd0, S_RD_REQ_MEM_WE}, 64'd0);
    wait_idle("idle_t3");

    // Zero-length write on req1: LEN passes unmodified and WDATA follows grant.
    @(negedge CLK);
    wr_go(1, 32'h0000_6000, 16'd0, 1'b1);
    @(negedge CLK);
    S_WR_REQ_START = '0;
    wait_start(1'b0, "wr_len0_timeout");
    chk("wr_wdata_req1", {32'd0, M_WR_REQ_MEM_WDATA}, 64'h5A5A_1111);
    wait_idle("idle_t4");

    // Repeated START while pending is ignored.
    base = rd_starts;
    @(negedge CLK);
    rd_go(0, 32'h0000_7000, 16'd8, 1'b1);
    @(negedge CLK);
    rd_go(0, 32'h0000_7100, 16'd9, 1'b0);
    @(negedge CLK);
    S_RD_REQ_START = '0;
    wait_idle("idle_t5");
    chk("rd_dup_start_count", 64'(rd_starts - base), 64'd1);

    // Reset while the read channel sits in WAIT_HIGH.
    rd_stall = 1'b1;
    @(negedge CLK);
    rd_go(0, 32'h0000_8000, 16'd64, 1'b1);
    @(negedge CLK);
    S_RD_REQ_START = '0;
    wait_start(1'b1, "rd_rst_start_timeout");
    repeat (4) @(negedge CLK);
    M_RD_REQ_MEM_WE = 1'b1;
    #1;
    chk("pre_rst_rd_ready", {62'd0, S_RD_REQ_READY}, 64'd2);
    chk("pre_rst_mem_we", {62'd0, S_RD_REQ_MEM_WE}, 64'd1);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_rd_ready", {62'd0, S_RD_REQ_READY}, 64'd3);
    chk("mid_rst_wr_ready", {62'd0, S_WR_REQ_READY}, 64'd3);
    chk("mid_rst_m_rd", {M_RD_REQ_ADDR, 16'd0, M_RD_REQ_LEN}, 64'd0);
    chk("mid_rst_m_start", {62'd0, M_WR_REQ_START, M_RD_REQ_START}, 64'd0);
    chk("mid_rst_mem_we", {62'd0, S_RD_REQ_MEM_WE}, 64'd0);
    @(negedge CLK);
    rd_stall = 1'b0;
    M_RD_REQ_MEM_WE = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    wait_idle("idle_t6");
    repeat (3) @(negedge CLK);

    chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
    chk("rd_q_empty", 64'(rd_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1);
  end

endmodule
